mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port 32-bit SRAM between the CPU fetch port (I), the CPU data port (D) and an external loader port (LD).
//  Sits between cpu and the unified SRAM macro. Returns i_stall/d_stall so the hazard logic can hold the pipeline when a port loses arbitration.
//  A halt/ack session parks the CPU so the loader can own memory for program download and readback.
// PARAMETERS
//  ADDR_W     16  byte address width, all ports
//  DATA_W     32  data width, all ports
//  STARVE_MAX 4   consecutive I losses before I is forced to win once (range 1..15)
// PORTS
//  clk       in   1       clock
//  rst       in   1       reset, synchronous, active-high
//  i_req     in   1       fetch read request (driven from isram_cs)
//  i_addr    in   ADDR_W  fetch address
//  i_stall   out  1       i_req asserted but not granted this cycle
//  i_rdata   out  DATA_W  fetch read data, valid one cycle after grant
//  d_req     in   1       data access request (load or store)
//  d_wen     in   4       byte write enables; 0 = read
//  d_addr    in   ADDR_W  data address
//  d_wdata   in   DATA_W  store data
//  d_stall   out  1       d_req asserted but not granted this cycle
//  d_rdata   out  DATA_W  load data, valid one cycle after grant
//  halt_req  in   1       loader requests memory ownership
//  halt_ack  out  1       CPU parked; LD owns memory
//  ld_valid  in   1       loader access valid
//  ld_ready  out  1       loader access accepted
//  ld_we     in   1       1 = write a full word, 0 = read
//  ld_addr   in   ADDR_W  loader address
//  ld_wdata  in   DATA_W  loader write data
//  ld_rvalid out  1       ld_rdata valid (one cycle after accepted read)
//  ld_rdata  out  DATA_W  loader read data
//  mem_cs    out  1       SRAM chip select
//  mem_wen   out  4       SRAM byte write enables
//  mem_addr  out  ADDR_W  SRAM address
//  mem_wdata out  DATA_W  SRAM write data
//  mem_rdata in   DATA_W  SRAM read data (registered in macro, 1-cycle latency)
// BEHAVIOUR
//  Reset: state RUN, owner tag OWN_NONE, starve_cnt 0. All outputs 0 except i_stall/d_stall, which are req-qualified (0 when idle).
//  FSM states: RUN, DRAIN_IN, LOAD, DRAIN_OUT.
//   RUN:       arbitrate I/D. halt_req=1 -> DRAIN_IN.
//   DRAIN_IN:  no new grants; both reqs stall. When owner tag = OWN_NONE -> LOAD.
//   LOAD:      halt_ack=1, ld_ready=1, I/D stall. halt_req=0 -> DRAIN_OUT.
//   DRAIN_OUT: ld_ready=0, halt_ack=1. When owner tag = OWN_NONE -> RUN.
//  Arbitration in RUN is combinational and same-cycle.
//   D beats I, except when starve_cnt = STARVE_MAX: then I wins and starve_cnt clears.
//   starve_cnt increments when I loses to D, clears on any I grant, and holds when I is idle.
//  Grant drives mem_cs=1 and the winner's addr/wen/wdata onto the mem_* pins. A fetch grant drives mem_wen=0.
//  LD access: ld_valid & ld_ready. ld_we=1 -> mem_wen=4'hF; ld_we=0 -> read.
//  Owner tag: registered each cycle to the granted reader (OWN_I, OWN_D or OWN_LD); OWN_NONE for writes or idle.
//   Next cycle mem_rdata is steered to the tagged port. Untagged *_rdata outputs hold their last value.
//   ld_rvalid = (tag == OWN_LD).
//  halt_req rising in the same cycle as a RUN grant: that grant completes; transition happens at that edge.
//  halt_req dropping during DRAIN_IN: still enter LOAD for one cycle, then DRAIN_OUT. No aborted handshakes.
//  Reset mid-operation: in-flight read is discarded (tag cleared), ld_rvalid=0, return to RUN.
//  No address range checks. Address wraps naturally at 2^ADDR_W.
// STRUCTURE
//  arb_pkg: owner_e {OWN_NONE, OWN_I, OWN_D, OWN_LD}, arb_state_e, default width constants.
//  One sub-module: arb_starve_ctr (saturating counter, inc/clr/hit ports).
//  Top level holds the FSM, grant mux, owner-tag register and read-data steering.
// TESTING
//  I-only stream, addr 0,4,8 -> mem_cs every cycle, i_stall=0, i_rdata matches memory one cycle later.
//  I and D both requesting 6 cycles, STARVE_MAX=4 -> D,D,D,D granted, then I on cycle 5, then D; i_stall=1 exactly on losses.
//  D store wen=4'b0011 @0x10 + simultaneous I -> mem_wen=4'b0011, tag OWN_NONE next cycle, i_rdata unchanged.
//  halt_req during D read -> DRAIN_IN one cycle; d_rdata delivered; halt_ack=1 on the following cycle.
//  LOAD: write 0xDEADBEEF @0x20, then read @0x20 -> ld_rvalid=1 with 0xDEADBEEF one cycle after accept.
//  rst asserted with read in flight -> next cycle all *_rvalid=0, state RUN, starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-SRAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned AddrWDef     = 16;
  localparam int unsigned DataWDef     = 32;
  localparam int unsigned StarveMaxDef = 4;
  localparam int unsigned WenW         = 4;
  // Wide enough for the largest legal STARVE_MAX (15).
  localparam int unsigned StarveCntW   = 4;

  // Which port the SRAM read issued last cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D,
    OWN_LD
  } owner_e;

  typedef enum logic [1:0] {
    StRun,
    StDrainIn,
    StLoad,
    StDrainOut
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I/D/LD request ports and the SRAM pins around the arbiter.
// slave: arbiter view; master: the CPU, loader and SRAM macro around it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_stall;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [3:0]        d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_stall;
  logic [DATA_W-1:0] d_rdata;

  logic              halt_req;
  logic              halt_ack;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic              mem_cs;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata,
    input  halt_req, ld_valid, ld_we, ld_addr, ld_wdata, mem_rdata,
    output i_stall, i_rdata, d_stall, d_rdata, halt_ack, ld_ready,
    output ld_rvalid, ld_rdata, mem_cs, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata,
    output halt_req, ld_valid, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  i_stall, i_rdata, d_stall, d_rdata, halt_ack, ld_ready,
    input  ld_rvalid, ld_rdata, mem_cs, mem_wen, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts consecutive fetch losses; hit forces one fetch grant.
module mem_port_arbiter_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX   = StarveMaxDef,
  parameter int unsigned CNT_W = StarveCntW
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [CNT_W-1:0] cnt_q;

  // Saturating loss counter; a clear wins over an increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(MAX))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between CPU fetch (I), CPU data (D) and the
// loader (LD). I/D arbitrate in RUN; a halt session hands memory to LD.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDef,
  parameter int unsigned DATA_W     = DataWDef,
  parameter int unsigned STARVE_MAX = StarveMaxDef
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e        state_q;
  logic              halt_ack_q;
  logic              ld_ready_q;
  owner_e            tag_q;
  owner_e            tag_d;
  logic [DATA_W-1:0] i_hold_q;
  logic [DATA_W-1:0] d_hold_q;
  logic [DATA_W-1:0] ld_hold_q;

  logic starve_hit;
  logic gnt_i;
  logic gnt_d;
  logic gnt_ld;

  mem_port_arbiter_starve_ctr #(
    .MAX   (STARVE_MAX),
    .CNT_W (StarveCntW)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (gnt_d && bus.i_req),
    .clr (gnt_i),
    .hit (starve_hit)
  );

  // Same-cycle grant: D beats I unless I has lost STARVE_MAX times in a row.
  always_comb begin
    gnt_i  = 1'b0;
    gnt_d  = 1'b0;
    gnt_ld = ld_ready_q && bus.ld_valid;
    if (state_q == StRun) begin
      if (bus.i_req && bus.d_req) begin
        gnt_i = starve_hit;
        gnt_d = !starve_hit;
      end else begin
        gnt_i = bus.i_req;
        gnt_d = bus.d_req;
      end
    end
  end

  // Winner's access onto the SRAM pins; a read grant tags next cycle's data.
  always_comb begin
    bus.mem_cs    = gnt_i || gnt_d || gnt_ld;
    bus.mem_wen   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    tag_d         = OWN_NONE;
    if (gnt_d) begin
      bus.mem_wen   = bus.d_wen;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      if (bus.d_wen == '0) tag_d = OWN_D;
    end else if (gnt_i) begin
      bus.mem_addr = bus.i_addr;
      tag_d        = OWN_I;
    end else if (gnt_ld) begin
      bus.mem_wen   = bus.ld_we ? 4'hF : 4'h0;
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_wdata;
      if (!bus.ld_we) tag_d = OWN_LD;
    end
  end

  // Halt session FSM. Drain states wait for the in-flight read to land,
  // which takes exactly one cycle since no new grants are issued there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      halt_ack_q <= 1'b0;
      ld_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.halt_req) state_q <= StDrainIn;
        end
        StDrainIn: begin
          if (tag_d == OWN_NONE) begin
            state_q    <= StLoad;
            halt_ack_q <= 1'b1;
            ld_ready_q <= 1'b1;
          end
        end
        StLoad: begin
          if (!bus.halt_req) begin
            state_q    <= StDrainOut;
            ld_ready_q <= 1'b0;
          end
        end
        StDrainOut: begin
          if (tag_d == OWN_NONE) begin
            state_q    <= StRun;
            halt_ack_q <= 1'b0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Owner tag and per-port hold registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= OWN_NONE;
      i_hold_q  <= '0;
      d_hold_q  <= '0;
      ld_hold_q <= '0;
    end else begin
      tag_q <= tag_d;
      if (tag_q == OWN_I)  i_hold_q  <= bus.mem_rdata;
      if (tag_q == OWN_D)  d_hold_q  <= bus.mem_rdata;
      if (tag_q == OWN_LD) ld_hold_q <= bus.mem_rdata;
    end
  end

  assign bus.i_stall   = bus.i_req && !gnt_i;
  assign bus.d_stall   = bus.d_req && !gnt_d;
  assign bus.halt_ack  = halt_ack_q;
  assign bus.ld_ready  = ld_ready_q;
  assign bus.ld_rvalid = (tag_q == OWN_LD);
  assign bus.i_rdata   = (tag_q == OWN_I)  ? bus.mem_rdata : i_hold_q;
  assign bus.d_rdata   = (tag_q == OWN_D)  ? bus.mem_rdata : d_hold_q;
  assign bus.ld_rdata  = (tag_q == OWN_LD) ? bus.mem_rdata : ld_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: the driver computes expected per-cycle outputs from a
// port-level model and queues them; the monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int StarveMax = 4;

  typedef struct packed {
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        halt_req;
    logic        ld_valid;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [31:0] ld_wdata;
  } stim_t;

  typedef struct packed {
    logic        i_stall;
    logic        d_stall;
    logic        cs;
    logic [3:0]  wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        halt_ack;
    logic        ld_ready;
    logic        ld_rvalid;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .STARVE_MAX (StarveMax)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        exp_q[$];
  logic [31:0] ld_q[$];

  // SRAM macro model: registered read, byte-enabled write.
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_wen == 4'h0) begin
        bus.mem_rdata <= sram[bus.mem_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wen[b]) sram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reference model state: session phase 0 run, 1 drain-in, 2 load, 3 drain-out.
  logic [31:0] ref_mem [256];
  int          phase = 0;
  int          losses = 0;
  int          pend = 0;  // 0 none, 1 I, 2 D, 3 LD
  logic [31:0] pend_data = '0;
  logic [31:0] hold_i = '0;
  logic [31:0] hold_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a[9:2]);
  endfunction

  // Apply one cycle of stimulus, queue its expectation, advance the model.
  task automatic drive_cycle(input stim_t s);
    exp_t        e;
    logic        gi, gd, gl;
    int          np;
    logic [31:0] nd;
    rst          = s.rst;
    bus.i_req    = s.i_req;
    bus.i_addr   = s.i_addr;
    bus.d_req    = s.d_req;
    bus.d_wen    = s.d_wen;
    bus.d_addr   = s.d_addr;
    bus.d_wdata  = s.d_wdata;
    bus.halt_req = s.halt_req;
    bus.ld_valid = s.ld_valid;
    bus.ld_we    = s.ld_we;
    bus.ld_addr  = s.ld_addr;
    bus.ld_wdata = s.ld_wdata;

    gi = 1'b0; gd = 1'b0; gl = 1'b0;
    if (phase == 0) begin
      if (s.i_req && s.d_req) begin
        if (losses == StarveMax) gi = 1'b1;
        else gd = 1'b1;
      end else begin
        gi = s.i_req;
        gd = s.d_req;
      end
    end else if (phase == 2) begin
      gl = s.ld_valid;
    end

    e = '0;
    e.i_stall   = s.i_req && !gi;
    e.d_stall   = s.d_req && !gd;
    e.cs        = gi || gd || gl;
    if (gd) begin
      e.wen = s.d_wen; e.addr = s.d_addr; e.wdata = s.d_wdata;
    end else if (gi) begin
      e.addr = s.i_addr;
    end else if (gl) begin
      e.wen = s.ld_we ? 4'hF : 4'h0; e.addr = s.ld_addr; e.wdata = s.ld_wdata;
    end
    e.halt_ack  = (phase == 2) || (phase == 3);
    e.ld_ready  = (phase == 2);
    e.ld_rvalid = (pend == 3);
    e.i_rdata   = (pend == 1) ? pend_data : hold_i;
    e.d_rdata   = (pend == 2) ? pend_data : hold_d;
    exp_q.push_back(e);

    if (pend == 1) hold_i = pend_data;
    if (pend == 2) hold_d = pend_data;
    np = 0; nd = '0;
    if (gi) begin
      np = 1; nd = ref_mem[widx(s.i_addr)];
    end else if (gd && s.d_wen == 4'h0) begin
      np = 2; nd = ref_mem[widx(s.d_addr)];
    end else if (gl && !s.ld_we) begin
      np = 3; nd = ref_mem[widx(s.ld_addr)];
    end
    if (gd && s.d_wen != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (s.d_wen[b]) ref_mem[widx(s.d_addr)][8*b +: 8] = s.d_wdata[8*b +: 8];
    end
    if (gl && s.ld_we) ref_mem[widx(s.ld_addr)] = s.ld_wdata;

    if (s.rst) begin
      phase = 0; losses = 0; pend = 0; pend_data = '0; hold_i = '0; hold_d = '0;
    end else begin
      pend = np;
      pend_data = nd;
      if (np == 3) ld_q.push_back(nd);
      if (gi) losses = 0;
      else if (gd && s.i_req) losses = losses + 1;
      case (phase)
        0: if (s.halt_req) phase = 1;
        1: phase = 2;
        2: if (!s.halt_req) phase = 3;
        default: phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each cycle's outputs; pops loader data on ld_rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("i_stall", bus.i_stall, e.i_stall);
        chk("d_stall", bus.d_stall, e.d_stall);
        chk("mem_cs", bus.mem_cs, e.cs);
        if (e.cs) begin
          chk("mem_wen", bus.mem_wen, e.wen);
          chk("mem_addr", bus.mem_addr, e.addr);
          if (e.wen != 4'h0) chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
        chk("halt_ack", bus.halt_ack, e.halt_ack);
        chk("ld_ready", bus.ld_ready, e.ld_ready);
        chk("ld_rvalid", bus.ld_rvalid, e.ld_rvalid);
        chk("i_rdata", bus.i_rdata, e.i_rdata);
        chk("d_rdata", bus.d_rdata, e.d_rdata);
      end
      if (bus.ld_rvalid === 1'b1) begin
        if (ld_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL ld_rvalid_unexpected: got 1, expected 0 at %0t", $time);
        end else begin
          chk("ld_rdata", bus.ld_rdata, ld_q.pop_front());
        end
      end
    end
  end

  function automatic logic [15:0] rand_addr();
    return 16'(($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 15));
  endfunction

  initial begin
    stim_t s;
    logic  halt_lvl;
    for (int k = 0; k < 256; k++) begin
      ref_mem[k] = $urandom;
      sram[k]    = ref_mem[k];
    end
    s = '0;
    {bus.i_req, bus.i_addr, bus.d_req, bus.d_wen, bus.d_addr, bus.d_wdata} = '0;
    {bus.halt_req, bus.ld_valid, bus.ld_we, bus.ld_addr, bus.ld_wdata} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_i_stall", bus.i_stall, 0);
    chk("rst_d_stall", bus.d_stall, 0);
    chk("rst_halt_ack", bus.halt_ack, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_ld_rvalid", bus.ld_rvalid, 0);
    chk("rst_mem_cs", bus.mem_cs, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_ld_rdata", bus.ld_rdata, 0);
    @(posedge clk);
    #1;

    // Fetch-only stream.
    for (int k = 0; k < 3; k++) begin
      s = '0; s.i_req = 1'b1; s.i_addr = 16'(k * 4);
      drive_cycle(s);
    end
    // Both ports requesting: starvation forces one fetch win.
    for (int k = 0; k < 6; k++) begin
      s = '0;
      s.i_req = 1'b1; s.i_addr = 16'(16'h40 + k * 4);
      s.d_req = 1'b1; s.d_addr = 16'(16'h80 + k * 4);
      drive_cycle(s);
    end
    // Partial store against a competing fetch.
    s = '0; s.i_req = 1'b1; s.i_addr = 16'h44;
    s.d_req = 1'b1; s.d_wen = 4'b0011; s.d_addr = 16'h10; s.d_wdata = 32'hA5A5_1234;
    drive_cycle(s);
    s = '0; drive_cycle(s);
    // Halt during a load, then loader write/readback session.
    s = '0; s.d_req = 1'b1; s.d_addr = 16'h10; s.halt_req = 1'b1; drive_cycle(s);
    s = '0; s.halt_req = 1'b1; s.i_req = 1'b1; drive_cycle(s);
    s = '0; s.halt_req = 1'b1; s.ld_valid = 1'b1; s.ld_we = 1'b1;
    s.ld_addr = 16'h20; s.ld_wdata = 32'hDEAD_BEEF; drive_cycle(s);
    s.ld_we = 1'b0; drive_cycle(s);
    s = '0; s.halt_req = 1'b1; drive_cycle(s);
    s = '0; drive_cycle(s);
    drive_cycle(s);
    drive_cycle(s);
    // Reset while a read is in flight and another is being granted.
    s = '0; s.d_req = 1'b1; s.d_addr = 16'h20; drive_cycle(s);
    s = '0; s.rst = 1'b1; s.d_req = 1'b1; s.d_addr = 16'h24; s.i_req = 1'b1; drive_cycle(s);
    s = '0; drive_cycle(s);

    // Randomized traffic with occasional halt sessions and resets.
    halt_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) halt_lvl = !halt_lvl;
      s = '0;
      s.rst      = ($urandom_range(0, 299) == 0);
      s.i_req    = ($urandom_range(0, 9) < 6);
      s.i_addr   = rand_addr();
      s.d_req    = ($urandom_range(0, 1) == 1);
      s.d_wen    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      s.d_addr   = rand_addr();
      s.d_wdata  = $urandom;
      s.halt_req = halt_lvl;
      s.ld_valid = ($urandom_range(0, 1) == 1);
      s.ld_we    = ($urandom_range(0, 1) == 1);
      s.ld_addr  = rand_addr();
      s.ld_wdata = $urandom;
      drive_cycle(s);
    end
    s = '0;
    repeat (4) drive_cycle(s);
    @(negedge clk);
    #1;
    chk("ld_q_drained", 32'(ld_q.size()), 0);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
